// File: rtl/reg_file_4x8.sv
// 4-entry register file (r0 hardwired zero), 1 write port, 2 independent read ports.
// Latency: reads registered, 1 cycle; write data bypasses to a same-cycle read of the same address.
// Backpressure: none; every write with a non-zero address is accepted in the cycle presented.
module reg_file_4x8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_addr_a,
  input  logic [1:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [3:0]       written,
  output logic [7:0]       wr_count
);

  // One-hot write enables for the stored registers; address 00 decodes to
  // nothing because r0 has no storage.
  logic [3:1]       wr_en_dec;
  logic             wr_accept;

  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] r3_q, r3_d;
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic [3:1]       written_q, written_d;
  logic [7:0]       wr_count_q, wr_count_d;

  // Read mux over next-state register values, so a write in the same cycle
  // is forwarded. Any select outside 01..11 (including X) yields zero and
  // only ever reaches the read output flops.
  function automatic logic [WIDTH-1:0] rd_mux(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] v1,
    input logic [WIDTH-1:0] v2,
    input logic [WIDTH-1:0] v3
  );
    logic [WIDTH-1:0] res;
    res = '0;
    case (sel)
      2'b01:   res = v1;
      2'b10:   res = v2;
      2'b11:   res = v3;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Write address decode and accept qualification.
  always_comb begin
    wr_en_dec = '0;
    if (wr_en) begin
      case (wr_addr)
        2'b01:   wr_en_dec[1] = 1'b1;
        2'b10:   wr_en_dec[2] = 1'b1;
        2'b11:   wr_en_dec[3] = 1'b1;
        default: wr_en_dec    = '0;
      endcase
    end
    wr_accept = |wr_en_dec;
  end

  // Next-state for storage, written flags, saturating counter and read data.
  always_comb begin
    r1_d        = wr_en_dec[1] ? wr_data : r1_q;
    r2_d        = wr_en_dec[2] ? wr_data : r2_q;
    r3_d        = wr_en_dec[3] ? wr_data : r3_q;
    written_d   = written_q | wr_en_dec;
    wr_count_d  = wr_count_q;
    if (wr_accept && (wr_count_q != 8'hFF)) begin
      wr_count_d = wr_count_q + 8'd1;
    end
    rd_data_a_d = rd_mux(rd_addr_a, r1_d, r2_d, r3_d);
    rd_data_b_d = rd_mux(rd_addr_b, r1_d, r2_d, r3_d);
  end

  // State registers; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      written_q   <= '0;
      wr_count_q  <= '0;
    end else begin
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      written_q   <= written_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign written   = {written_q, 1'b0};
  assign wr_count  = wr_count_q;

endmodule

// File: doc/reg_file_4x8.md
REG_FILE_4X8 -- requirements
Module: reg_file_4x8

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each register and of every data port.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: wr_en  input  1  write request for the current cycle.
REQ-005 Port: wr_addr  input  2  write select; bit1 = s1, bit0 = s0; decodes one-hot to registers 0..3 (00->r0, 01->r1, 10->r2, 11->r3).
REQ-006 Port: wr_data  input  WIDTH  write data.
REQ-007 Port: rd_addr_a  input  2  read port A register select.
REQ-008 Port: rd_addr_b  input  2  read port B register select.
REQ-009 Port: rd_data_a  output  WIDTH  registered read data, port A.
REQ-010 Port: rd_data_b  output  WIDTH  registered read data, port B.
REQ-011 Port: written  output  4  bit n = 1 once register n has been written since last reset.
REQ-012 Port: wr_count  output  8  count of accepted writes since reset, saturating.

Function
REQ-013 Storage SHALL be registers r1..r3, each WIDTH bits; r0 SHALL be hardwired zero with no storage.
REQ-014 Write decode SHALL produce one-hot enables en0..en3 = wr_en AND decoded wr_addr; exactly one or zero enables active per cycle.
REQ-015 A write is accepted when wr_en=1, wr_addr!=00 and reset=0; the selected register SHALL take wr_data at that rising edge.
REQ-016 A write with wr_addr=00 SHALL be ignored: no storage change, written[0] unchanged, wr_count unchanged.
REQ-017 Reads SHALL have latency 1: rd_data_x at cycle N+1 reflects rd_addr_x sampled at edge N.
REQ-018 Reading address 00 SHALL return all zeros regardless of any write.
REQ-019 Read-during-write bypass: if at edge N a write is accepted to address k and rd_addr_x=k, rd_data_x after edge N SHALL equal the new wr_data, not the old contents.
REQ-020 Ports A and B SHALL be independent; both may read the same register, including during a bypassed write, and both receive identical data.
REQ-021 written[k] (k=1..3) SHALL set on the first accepted write to rk and hold until reset; written[0] SHALL be constant 0.
REQ-022 wr_count SHALL increment by 1 per accepted write and saturate at 255 (no wrap to 0).
REQ-023 With wr_en=0 all stored registers, written and wr_count SHALL hold; rd_data_x still updates per REQ-017.
REQ-024 Unknown or changing read addresses SHALL only affect read outputs, never stored state.

Reset
REQ-025 When reset=1 at a rising edge: r1..r3 <= 0, rd_data_a <= 0, rd_data_b <= 0, written <= 0000, wr_count <= 0.
REQ-026 Reset SHALL take priority over a simultaneous write; that write is discarded and not counted.
REQ-027 Reset asserted mid-sequence SHALL discard all prior contents; the first cycle after reset deasserts behaves as a fresh start.
REQ-028 Outputs SHALL not change between clock edges (no combinational path from inputs to outputs).

Verification
REQ-029 Reset, then read r0..r3 on both ports -> all rd_data = 0x00, written=0000, wr_count=0.
REQ-030 Write 0xA5 to addr 01, 0x3C to 10, 0xFF to 11; then read A=01, B=11 -> next cycle rd_data_a=0xA5, rd_data_b=0xFF; written=1110, wr_count=3.
REQ-031 Write 0x77 to addr 00, read A=00 -> rd_data_a=0x00, written[0]=0, wr_count unchanged.
REQ-032 r2=0x3C; same cycle write 0x99 to 10 with rd_addr_a=rd_addr_b=10 -> next cycle both rd_data=0x99 (bypass).
REQ-033 Issue 300 consecutive writes to addr 11 -> wr_count stops at 255; r3 holds last data written.
REQ-034 With r1=0xA5, assert reset together with write 0x11 to 01 -> after edge r1 reads 0x00, written=0000, wr_count=0.
